// File: rtl/fir_coeff_loader.sv
// Coefficient loader for the 5x5 systolic FIR: reads a packed tap set into a shadow copy and swaps it active on vs.
// Optional FIR_COEFF_RESET_IDENT_EN: reset value of the tap sets is an identity kernel (centre tap = 1.0 in Q8.8).
module fir_coeff_loader #(
    parameter int NUM_COEFF   = 25,
    parameter int COEFF_W     = 16,
    parameter int ADDR_W      = 6,
    parameter int MEM_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         vs_i,
    input  logic                         reload_req_i,
    input  logic [ADDR_W-1:0]            coeff_base_i,
    output logic                         filter_coeff_rd_o,
    output logic [ADDR_W-1:0]            filter_coeff_addr,
    input  logic [31:0]                  filter_coeff_data,
    output logic [NUM_COEFF*COEFF_W-1:0] coeff_o,
    output logic                         busy_o,
    output logic                         swap_o,
    output logic [1:0]                   state_dbg
);

    localparam int NWORDS = (NUM_COEFF + 1) / 2;
    localparam int CNT_W  = $clog2(NWORDS + 1);

    // Handshake: a read is issued in every cycle filter_coeff_rd_o is high; the
    // memory answers MEM_LATENCY cycles later with no back-pressure.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        READY = 2'd3
    } state_t;

    state_t               state, state_nxt;
    logic [ADDR_W-1:0]    base;
    logic [CNT_W-1:0]     cnt;
    logic                 pending, vs_d, vs_edge;
    logic                 start, rd, swap, last_cap;
    logic [MEM_LATENCY-1:0] vld_pipe;
    logic [CNT_W-1:0]     idx_pipe [MEM_LATENCY];
    logic [COEFF_W-1:0]   shadow   [NUM_COEFF];
    logic [COEFF_W-1:0]   active   [NUM_COEFF];

    function automatic logic [COEFF_W-1:0] reset_tap(input int i);
        logic ident;
`ifdef FIR_COEFF_RESET_IDENT_EN
        ident = 1'b1;
`else
        ident = 1'b0;
`endif
        reset_tap = (ident && i == NUM_COEFF / 2) ? COEFF_W'(256) : '0;
    endfunction

    assign vs_edge  = vs_i & ~vs_d;
    assign last_cap = vld_pipe[MEM_LATENCY-1] && (idx_pipe[MEM_LATENCY-1] == CNT_W'(NWORDS - 1));

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        rd        = 1'b0;
        swap      = 1'b0;
        case (state)
            IDLE: begin
                // A vs edge coinciding with a request is deliberately not acted upon here.
                if (reload_req_i || pending) begin
                    start     = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                rd = 1'b1;
                if (cnt == CNT_W'(NWORDS - 1)) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (last_cap) state_nxt = READY;
            end
            READY: begin
                if (vs_edge) begin
                    swap      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            vs_d    <= 1'b0;
            base    <= '0;
            cnt     <= '0;
            pending <= 1'b0;
        end else begin
            state <= state_nxt;
            vs_d  <= vs_i;
            if (start) begin
                base <= coeff_base_i;
                cnt  <= '0;
            end else if (state == ISSUE && cnt != CNT_W'(NWORDS - 1)) begin
                cnt <= cnt + 1'b1;
            end
            if (start)
                pending <= 1'b0;
            else if (reload_req_i && state != IDLE)
                pending <= 1'b1;
        end
    end

    // Valid/index pipeline mirrors the memory read latency so each returning word lands on its taps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
            for (int i = 0; i < MEM_LATENCY; i++) idx_pipe[i] <= '0;
        end else begin
            vld_pipe[0] <= rd;
            idx_pipe[0] <= cnt;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                idx_pipe[i] <= idx_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_COEFF; i++) begin
                shadow[i] <= reset_tap(i);
                active[i] <= reset_tap(i);
            end
        end else begin
            if (vld_pipe[MEM_LATENCY-1]) begin
                for (int i = 0; i < NUM_COEFF; i++)
                    if (CNT_W'(i / 2) == idx_pipe[MEM_LATENCY-1])
                        shadow[i] <= filter_coeff_data[(i % 2) * 16 +: COEFF_W];
            end
            if (swap) begin
                for (int i = 0; i < NUM_COEFF; i++) active[i] <= shadow[i];
            end
        end
    end

    always_comb begin
        coeff_o = '0;
        for (int i = 0; i < NUM_COEFF; i++) coeff_o[i*COEFF_W +: COEFF_W] = active[i];
    end

    assign filter_coeff_rd_o = rd;
    assign filter_coeff_addr = base + ADDR_W'(cnt);
    assign busy_o            = (state != IDLE);
    assign swap_o            = swap;
    assign state_dbg         = state;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader: one instance at MEM_LATENCY 1, one at MEM_LATENCY 3, sharing vs and reset.
module tb_fir_coeff_loader;

    logic         clk = 1'b0;
    logic         rst, vs, req, req3;
    logic [5:0]   base_in;
    logic         rd1, rd3, busy1, busy3, swap1, swap3;
    logic [5:0]   addr1, addr3;
    logic [31:0]  data1, data3, p1, p2;
    logic [399:0] coeff1, coeff3;
    logic [1:0]   state1, state3;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int swap_cnt = 0;
    logic [5:0] exp_q[$];

    always #5 clk = ~clk;

    fir_coeff_loader #(.MEM_LATENCY(1)) dut (
        .clk(clk), .rst(rst), .vs_i(vs), .reload_req_i(req), .coeff_base_i(base_in),
        .filter_coeff_rd_o(rd1), .filter_coeff_addr(addr1), .filter_coeff_data(data1),
        .coeff_o(coeff1), .busy_o(busy1), .swap_o(swap1), .state_dbg(state1)
    );

    fir_coeff_loader #(.MEM_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .vs_i(vs), .reload_req_i(req3), .coeff_base_i(base_in),
        .filter_coeff_rd_o(rd3), .filter_coeff_addr(addr3), .filter_coeff_data(data3),
        .coeff_o(coeff3), .busy_o(busy3), .swap_o(swap3), .state_dbg(state3)
    );

    function automatic logic [31:0] mem_word(input int n);
        mem_word = {16'(2 * n + 1), 16'(2 * n)};
    endfunction

    // Memory models: registered read, plus two extra stages for the latency-3 instance.
    always @(posedge clk) begin
        data1 <= mem_word(int'(addr1));
        p1    <= mem_word(int'(addr3));
        p2    <= p1;
        data3 <= p2;
    end

    function automatic logic [399:0] exp_set(input int b);
        logic [31:0] w;
        exp_set = '0;
        for (int i = 0; i < 25; i++) begin
            w = mem_word((b + i / 2) % 64);
            exp_set[i*16 +: 16] = (i % 2 == 1) ? w[31:16] : w[15:0];
        end
    endfunction

    function automatic logic [399:0] reset_set();
        reset_set = '0;
`ifdef FIR_COEFF_RESET_IDENT_EN
        reset_set[12*16 +: 16] = 16'h0100;
`endif
    endfunction

    task automatic check(input string tag, input logic [399:0] got, input logic [399:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_addrs(input int b);
        for (int j = 0; j < 13; j++) exp_q.push_back(6'((b + j) % 64));
    endtask

    // Scoreboard: every issued read must match the next expected address.
    always begin
        @(negedge clk);
        #2;
        if (rst === 1'b1 && rd1 === 1'b1) begin
            if (exp_q.size() == 0) check("rd_unexpected", rd1, 0);
            else check("addr", addr1, exp_q.pop_front());
            rd_cnt++;
        end
        if (swap1 === 1'b1) swap_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; vs = 1'b0; req = 1'b0; req3 = 1'b0; base_in = '0;
        repeat (3) @(negedge clk);
        #2;
        check("rst_busy", busy1, 0);
        check("rst_rd", rd1, 0);
        check("rst_addr", addr1, 0);
        check("rst_swap", swap1, 0);
        check("rst_coeff", coeff1, reset_set());
        check("rst_state", state1, 0);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);

        // Base 0, both latencies: 13 reads, swap on first vs edge in READY.
        push_addrs(0);
        for (int c = 0; c <= 19; c++) begin
            if (c > 0) @(negedge clk);
            req = (c == 0); req3 = (c == 0); base_in = 6'd0; vs = (c == 18);
            #2;
            case (c)
                0:  check("t1_rd_c0", rd1, 0);
                1:  begin check("t1_rd_c1", rd1, 1); check("t1_busy", busy1, 1); end
                13: check("t1_rd_c13", rd1, 1);
                14: begin check("t1_rd_c14", rd1, 0); check("t1_drain", state1, 2); end
                15: begin
                    check("t1_ready", state1, 3);
                    check("t1_l3_drain", state3, 2);
                    check("t1_l3_busy", busy3, 1);
                    check("t1_coeff_hold", coeff1, reset_set());
                end
                16: check("t1_l3_not_ready", state3, 2);
                17: check("t1_l3_ready", state3, 3);
                18: begin check("t1_swap", swap1, 1); check("t1_l3_swap", swap3, 1); end
                19: begin
                    check("t1_coeff", coeff1, exp_set(0));
                    check("t1_l3_coeff", coeff3, exp_set(0));
                    check("t1_idle", busy1, 0);
                    check("t1_swap_end", swap1, 0);
                    check("t1_swap_cnt", swap_cnt, 1);
                    check("t1_rd_cnt", rd_cnt, 13);
                end
                default: ;
            endcase
        end

        // Base 60 wraps the address; vs edges in ISSUE and DRAIN are ignored.
        push_addrs(60);
        for (int c = 0; c <= 17; c++) begin
            @(negedge clk);
            req = (c == 0); base_in = 6'd60; vs = (c == 3 || c == 14 || c == 16);
            #2;
            case (c)
                3:  check("t2_vs_issue", swap1, 0);
                14: begin check("t2_vs_drain", swap1, 0); check("t2_drain", state1, 2); end
                15: begin check("t2_ready", state1, 3); check("t2_coeff_hold", coeff1, exp_set(0)); end
                16: check("t2_swap", swap1, 1);
                17: begin
                    check("t2_coeff", coeff1, exp_set(60));
                    check("t2_swap_cnt", swap_cnt, 2);
                    check("t2_rd_cnt", rd_cnt, 26);
                end
                default: ;
            endcase
        end

        // Three requests during ISSUE collapse into one pending load that picks up the new base.
        push_addrs(0);
        push_addrs(20);
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            req = (c == 0 || c == 2 || c == 5 || c == 9);
            base_in = (c == 0) ? 6'd0 : 6'd20;
            vs = (c == 16 || c == 33);
            #2;
            case (c)
                15: check("t3_ready1", state1, 3);
                16: check("t3_swap1", swap1, 1);
                17: begin
                    check("t3_coeff1", coeff1, exp_set(0));
                    check("t3_idle_gap", state1, 0);
                end
                18: begin check("t3_rd2", rd1, 1); check("t3_busy2", busy1, 1); end
                32: check("t3_ready2", state1, 3);
                33: check("t3_swap2", swap1, 1);
                34: check("t3_coeff2", coeff1, exp_set(20));
                40: begin
                    check("t3_no_third", busy1, 0);
                    check("t3_rd_cnt", rd_cnt, 52);
                    check("t3_swap_cnt", swap_cnt, 4);
                    check("t3_q_empty", exp_q.size(), 0);
                end
                default: ;
            endcase
        end

        // Reset during DRAIN abandons the load.
        push_addrs(0);
        for (int c = 0; c <= 18; c++) begin
            @(negedge clk);
            req = (c == 0); base_in = 6'd0; vs = (c == 17);
            if (c == 15) rst = 1'b1;
            #2;
            case (c)
                14: begin
                    check("t4_drain", state1, 2);
                    rst = 1'b0;
                    #1;
                    check("t4_rst_busy", busy1, 0);
                    check("t4_rst_coeff", coeff1, reset_set());
                    check("t4_rst_state", state1, 0);
                end
                17: check("t4_no_swap", swap1, 0);
                18: begin
                    check("t4_coeff", coeff1, reset_set());
                    check("t4_busy", busy1, 0);
                end
                default: ;
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
